// File: rtl/tvip_clock_monitor.sv
// Measures the period of an asynchronous monitored clock in clk cycles and tracks its start/stop.
// Optional min/max/jitter tracking is built when TVIP_CLOCK_MONITOR_JITTER_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | after reset/clear, waiting for the first monitored rise
// MEASURE | one rise seen, counting toward the first period
// RUNNING | periods are being measured on every rise
// STOPPED | no rise within TIMEOUT_CYCLES; last period kept but invalid
module tvip_clock_monitor #(
    parameter int COUNTER_WIDTH    = 16,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int JITTER_TOLERANCE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_mon_clk,
    input  logic                     i_clear,
    output logic [COUNTER_WIDTH-1:0] o_period,
    output logic                     o_period_valid,
    output logic                     o_period_update,
    output logic                     o_running,
    output logic                     o_stopped,
    output logic [COUNTER_WIDTH-1:0] o_min_period,
    output logic [COUNTER_WIDTH-1:0] o_max_period,
    output logic                     o_jitter_error
);

    typedef enum logic [1:0] {IDLE, MEASURE, RUNNING, STOPPED} state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_M1 = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_next;
    logic [SYNC_STAGES-1:0]   sync;
    logic                     hist;
    logic                     rise;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] period_meas;
    logic                     timeout;
    logic                     write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_mon_clk};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise        = sync[SYNC_STAGES-1] & ~hist;
    assign timeout     = (count == TIMEOUT_M1);
    assign period_meas = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;

    always_comb begin
        state_next = state;
        write      = 1'b0;
        if (i_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_next = MEASURE;
                MEASURE: begin
                    if (rise) begin
                        state_next = RUNNING;
                        write      = 1'b1;
                    end else if (timeout) begin
                        state_next = STOPPED;
                    end
                end
                RUNNING: begin
                    if (rise) write = 1'b1;
                    else if (timeout) state_next = STOPPED;
                end
                STOPPED: if (rise) state_next = MEASURE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (i_clear || rise || state == IDLE) count <= '0;
            else if (count != CNT_MAX) count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_period        <= '0;
            o_period_valid  <= 1'b0;
            o_period_update <= 1'b0;
        end else begin
            o_period_update <= write;
            if (i_clear) begin
                o_period       <= '0;
                o_period_valid <= 1'b0;
            end else if (write) begin
                o_period       <= period_meas;
                o_period_valid <= 1'b1;
            end else if (state_next == STOPPED) begin
                o_period_valid <= 1'b0;
            end
        end
    end

    assign o_running = (state == RUNNING);
    assign o_stopped = (state == STOPPED);

`ifdef TVIP_CLOCK_MONITOR_JITTER_CHECK_EN
    logic [COUNTER_WIDTH-1:0] prev_period;
    logic [COUNTER_WIDTH-1:0] delta;

    assign delta = (period_meas > prev_period) ? period_meas - prev_period
                                               : prev_period - period_meas;

    // The first period after MEASURE seeds min/max and is never compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_period    <= '0;
            o_min_period   <= '0;
            o_max_period   <= '0;
            o_jitter_error <= 1'b0;
        end else if (i_clear) begin
            prev_period    <= '0;
            o_min_period   <= '0;
            o_max_period   <= '0;
            o_jitter_error <= 1'b0;
        end else if (write) begin
            prev_period <= period_meas;
            if (state == MEASURE) begin
                o_min_period <= period_meas;
                o_max_period <= period_meas;
            end else begin
                if (period_meas < o_min_period) o_min_period <= period_meas;
                if (period_meas > o_max_period) o_max_period <= period_meas;
                if (delta > COUNTER_WIDTH'(JITTER_TOLERANCE)) o_jitter_error <= 1'b1;
            end
        end
    end
`else
    assign o_min_period   = '0;
    assign o_max_period   = '0;
    assign o_jitter_error = 1'b0;
`endif

endmodule

// File: tb/tb_tvip_clock_monitor.sv
// Directed bench for tvip_clock_monitor: expected periods are queued per monitored rise
// and popped when the DUT pulses o_period_update.
module tb_tvip_clock_monitor;

    localparam int W       = 16;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mon_clk = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] period, min_period, max_period;
    logic         period_valid, period_update, running, stopped, jitter_error;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    int last_upd_cyc = 0;
    int stop_cyc = 0;
    bit stop_seen = 0;
    bit prev_upd = 0;
    bit armed = 0;
    int last_p = 0;
    int exp_q[$];

    tvip_clock_monitor #(
        .COUNTER_WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT), .JITTER_TOLERANCE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_mon_clk(mon_clk), .i_clear(clear),
        .o_period(period), .o_period_valid(period_valid), .o_period_update(period_update),
        .o_running(running), .o_stopped(stopped), .o_min_period(min_period),
        .o_max_period(max_period), .o_jitter_error(jitter_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each rise after the first of a run is expected to report the spacing that preceded it.
    task automatic mon_train(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            if (armed) exp_q.push_back(last_p);
            armed  = 1;
            last_p = p;
            mon_clk = 1'b1;
            repeat (p / 2) @(negedge clk);
            mon_clk = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_valid"}, period_valid, 0);
        check({tag, "_update"}, period_update, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_stopped"}, stopped, 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n && period_update) begin
            if (prev_upd) check("update_one_cycle", 1, 0);
            if (exp_q.size() == 0) check("spurious_update", 1, 0);
            else check("period", period, exp_q.pop_front());
            last_upd_cyc = cyc;
        end
        prev_upd = period_update;
        if (stopped && !stop_seen) begin
            stop_cyc  = cyc;
            stop_seen = 1;
        end else if (!stopped) begin
            stop_seen = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_jitter", jitter_error, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("post_reset");

        // steady period 10
        armed = 0;
        mon_train(10, 5);
        check("steady_period", period, 10);
        check("steady_valid", period_valid, 1);
        check("steady_running", running, 1);
        check("steady_queue", exp_q.size(), 0);

        // period change 10 -> 16 without going through STOPPED
        mon_train(16, 3);
        check("change_period", period, 16);
        check("change_stopped", stopped, 0);
        check("change_running", running, 1);
        check("change_queue", exp_q.size(), 0);

        // stop and timeout
        begin
            int k = 0;
            while (!stopped && k < 300) begin
                @(negedge clk);
                k++;
            end
            check("stop_seen", stopped, 1);
        end
        @(negedge clk);
        check("stop_latency", stop_cyc - last_upd_cyc, TIMEOUT);
        check("stop_running", running, 0);
        check("stop_valid", period_valid, 0);
        check("stop_period_kept", period, 16);

        // restart from STOPPED: first rise only re-enters MEASURE
        armed = 0;
        mon_train(12, 3);
        check("restart_period", period, 12);
        check("restart_valid", period_valid, 1);
        check("restart_running", running, 1);
        check("restart_stopped", stopped, 0);
        check("restart_queue", exp_q.size(), 0);

        // clear coincident with a detected rise (rise reaches the FSM 3 edges after the input)
        armed = 0;
        mon_clk = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        mon_clk = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("clear");
        mon_train(10, 3);
        check("after_clear_period", period, 10);
        check("after_clear_queue", exp_q.size(), 0);

        // async reset mid-period, clock continues at period 8
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        armed = 0;
        mon_train(8, 4);
        check("reset_resume_period", period, 8);
        check("reset_resume_running", running, 1);
        repeat (10) @(negedge clk);
        check("final_queue", exp_q.size(), 0);

`ifndef TVIP_CLOCK_MONITOR_JITTER_CHECK_EN
        check("min_tied", min_period, 0);
        check("max_tied", max_period, 0);
        check("jitter_tied", jitter_error, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
